unit_forward_sb: RTL and testbench
==================================

# unit_forward_sb

Scoreboard-based forwarding and load-use hazard unit for the MIPS-DLX pipeline. It generalises the combinational EX/MEM–MEM/WB forwarding unit to a parametrised number of tracked post-ID stages. It carries its own shift register of in-flight destination registers, so the pipeline registers no longer need to export write-register fields. It also detects load-use hazards, generates the ID stall, and keeps a saturating stall-cycle counter. It sits between the ID stage and the EX operand muxes.

## Interface
- NB_REG, 5, register-index width
- DEPTH, 3, tracked stages after ID (1 = EX, 2 = EX/MEM, 3 = MEM/WB, …); legal range ≥ 2
- LOAD_READY, 3, first tracked stage from which load data is forwardable; legal range 2..DEPTH
- NB_SEL, $clog2(DEPTH), forward-select width
- NB_CNT, 16, stall counter width

- i_clock  in  1  clock, rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_halt  in  1  global pipeline freeze
- i_flush  in  1  kill the instruction currently in ID
- i_id_valid  in  1  ID holds a real instruction
- i_id_rs, i_id_rt  in  NB_REG  ID source registers
- i_id_use_rs, i_id_use_rt  in  1  operand actually read
- i_id_write_reg  in  NB_REG  ID destination register
- i_id_reg_write  in  1  ID instruction writes the register file
- i_id_mem_to_reg  in  1  ID instruction is a load
- o_forward_A, o_forward_B  out  NB_SEL  EX operand source select
- o_stall  out  1  hold PC/IF/ID; insert a bubble into EX
- o_stall_count  out  NB_CNT  saturating stall-cycle count

## Operation
- Entry e[j], j = 1..DEPTH, fields:
  - valid, reg_write, write_reg, is_load
  - e[1] also stores rs, rt, use_rs, use_rt
- Matching entry:
  - valid & reg_write & write_reg == operand & operand != 0
  - "Youngest match" is the matching entry with the smallest j.
- Forward select for EX operand rs (rt is identical):
  - Output is 0 (register file) if e[1] is invalid or !use_rs.
  - Otherwise take the youngest match among j = 2..DEPTH. Output DEPTH+1−j when that entry is not a load, or is a load with j ≥ LOAD_READY.
  - No match: output 0.
  - With DEPTH = 3 this gives EX/MEM = 2'b10 and MEM/WB = 2'b01, the legacy encoding.
- Hazard:
  - Exists when i_id_valid is set and, for a used ID operand, the youngest match among j = 1..DEPTH is a load with j ≤ LOAD_READY−2.
  - o_stall = hazard & ~i_flush.
- Update on each rising edge when i_halt = 0:
  - e[j+1] ← e[j] for j = 1..DEPTH−1; e[DEPTH] retires.
  - e[1] ← ID fields if i_id_valid & ~o_stall & ~i_flush; otherwise e[1] ← bubble (valid = 0).
  - o_stall_count increments by 1 when o_stall = 1 and saturates at 2^NB_CNT−1.
- i_halt = 1: all state and the counter hold. Outputs still reflect the current state and inputs.
- Flush and stall in the same cycle: flush wins. o_stall = 0, bubble inserted, counter unchanged.
- Register 0 never matches, forwards or stalls.

## Timing
- Reset (i_reset = 0, asynchronous):
  - All entries invalid and o_stall_count = 0.
  - Hence o_forward_A = o_forward_B = 0 and o_stall = 0 (given i_id_valid = 0).
  - Reset mid-stall clears the hazard immediately. The first edge after release accepts ID normally.
- o_forward_A/B are combinational from registered state only, valid the whole cycle after the edge that loads e[1].
- o_stall is combinational from ID inputs and state, same cycle.
- Load-use with defaults: exactly 1 stall cycle.
  - Edge 1: the load is in e[1]; the dependent instruction in ID sees o_stall = 1.
  - Edge 2: a bubble enters; the load moves to e[2]; o_stall drops.
  - Edge 3: the dependent instruction enters e[1]; the load is in e[3]; select = 01.
- Generally a load costs LOAD_READY−2 stall cycles; ALU results cost 0.
- Hold latency through halt: state is frozen; no cycle is lost or duplicated on release.

## Test plan
- Reset: drive i_reset = 0 mid-sequence with entries valid → all outputs 0 immediately; o_stall_count = 0.
- ALU chain: add r2 ← …, then sub reads rs = r2, then or reads rt = r2 → sub gets o_forward_A = 10; or gets o_forward_B = 01; o_stall never asserted.
- Load-use: lw r4, then add rs = r4 → o_stall = 1 for exactly 1 cycle; one bubble; add gets o_forward_A = 01; o_stall_count = 1.
- Youngest wins and r0: writes to r5 at e[3] and e[2] → select 10. Any writes to r0 → select 00, no stall.
- Flush/halt:
  - Flush during a load-use hazard → o_stall = 0 and the count is unchanged.
  - i_halt for 3 cycles → selects and count frozen; sequence resumes identically.
- Parametric: DEPTH = 4, LOAD_READY = 4; lw r7 then use r7 →
  - 2 stall cycles;
  - select = 1 (forward from e[4]);
  - an ALU producer at e[2] gives select 3.

Source files
------------

// File: rtl/unit_forward_sb.sv
// unit_forward_sb: scoreboard-based operand forwarding and load-use hazard unit.
// Tracks the destination registers of the DEPTH instructions in flight after ID.
// It selects the EX operand source for each operand, stalls ID on a load-use
// hazard, and counts stall cycles with a saturating counter.
//
// Ports:
//   i_clock, i_reset       clock (rising edge), asynchronous active-low reset
//   i_halt                 freeze all state (outputs still track state/inputs)
//   i_flush                kill the instruction currently in ID
//   i_id_*                 ID-stage instruction fields
//   o_forward_A/B          EX operand select: 0 = register file, DEPTH+1-j = stage j
//   o_stall                hold PC/IF/ID and insert a bubble into EX
//   o_stall_count          saturating count of stall cycles
module unit_forward_sb #(
    parameter int unsigned NB_REG     = 5,
    parameter int unsigned DEPTH      = 3,
    parameter int unsigned LOAD_READY = 3,
    parameter int unsigned NB_SEL     = $clog2(DEPTH),
    parameter int unsigned NB_CNT     = 16
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_halt,
    input  logic              i_flush,
    input  logic              i_id_valid,
    input  logic [NB_REG-1:0] i_id_rs,
    input  logic [NB_REG-1:0] i_id_rt,
    input  logic              i_id_use_rs,
    input  logic              i_id_use_rt,
    input  logic [NB_REG-1:0] i_id_write_reg,
    input  logic              i_id_reg_write,
    input  logic              i_id_mem_to_reg,
    output logic [NB_SEL-1:0] o_forward_A,
    output logic [NB_SEL-1:0] o_forward_B,
    output logic              o_stall,
    output logic [NB_CNT-1:0] o_stall_count
);

    // Scoreboard entries; index 1 is the instruction now in EX.
    logic [DEPTH:1]    e_valid;
    logic [DEPTH:1]    e_reg_write;
    logic [DEPTH:1]    e_is_load;
    logic [NB_REG-1:0] e_write_reg [1:DEPTH];

    // Source operands of the EX instruction, kept to drive its forward selects.
    logic [NB_REG-1:0] e1_rs;
    logic [NB_REG-1:0] e1_rt;
    logic              e1_use_rs;
    logic              e1_use_rt;

    logic [DEPTH:1] m_ex_rs;
    logic [DEPTH:1] m_ex_rt;
    logic [DEPTH:1] m_id_rs;
    logic [DEPTH:1] m_id_rt;
    logic           hazard;
    logic           accept;

    // Youngest match among stages 2..DEPTH; a load still short of LOAD_READY yields 0.
    function automatic logic [NB_SEL-1:0] fwd_sel(input logic [DEPTH:1] m,
                                                  input logic [DEPTH:1] ld);
        logic [NB_SEL-1:0] sel;
        logic              done;
        sel  = '0;
        done = 1'b0;
        for (int unsigned j = 2; j <= DEPTH; j++) begin
            if (!done && m[j]) begin
                done = 1'b1;
                if (!ld[j] || (j >= LOAD_READY)) begin
                    sel = NB_SEL'(DEPTH + 1 - j);
                end
            end
        end
        return sel;
    endfunction

    // Youngest match over all stages is a load whose data cannot reach EX in time.
    function automatic logic load_hazard(input logic [DEPTH:1] m,
                                         input logic [DEPTH:1] ld);
        logic hz;
        logic done;
        hz   = 1'b0;
        done = 1'b0;
        for (int unsigned j = 1; j <= DEPTH; j++) begin
            if (!done && m[j]) begin
                done = 1'b1;
                hz   = ld[j] && ((j + 2) <= LOAD_READY);
            end
        end
        return hz;
    endfunction

    // Per-stage register matches for EX and ID operands; r0 never matches.
    always_comb begin
        m_ex_rs = '0;
        m_ex_rt = '0;
        m_id_rs = '0;
        m_id_rt = '0;
        for (int unsigned j = 1; j <= DEPTH; j++) begin
            m_ex_rs[j] = e_valid[j] & e_reg_write[j] & (e_write_reg[j] == e1_rs) & (e1_rs != '0);
            m_ex_rt[j] = e_valid[j] & e_reg_write[j] & (e_write_reg[j] == e1_rt) & (e1_rt != '0);
            m_id_rs[j] = e_valid[j] & e_reg_write[j] & (e_write_reg[j] == i_id_rs) & (i_id_rs != '0);
            m_id_rt[j] = e_valid[j] & e_reg_write[j] & (e_write_reg[j] == i_id_rt) & (i_id_rt != '0);
        end
    end

    // Forward selects depend on registered state only.
    always_comb begin
        o_forward_A = '0;
        o_forward_B = '0;
        if (e_valid[1] && e1_use_rs) begin
            o_forward_A = fwd_sel(m_ex_rs, e_is_load);
        end
        if (e_valid[1] && e1_use_rt) begin
            o_forward_B = fwd_sel(m_ex_rt, e_is_load);
        end
    end

    // Flush wins over stall: the killed instruction needs no operands.
    assign hazard  = i_id_valid & ((i_id_use_rs & load_hazard(m_id_rs, e_is_load)) |
                                   (i_id_use_rt & load_hazard(m_id_rt, e_is_load)));
    assign o_stall = hazard & ~i_flush;
    assign accept  = i_id_valid & ~o_stall & ~i_flush;

    // Scoreboard shift and stall counter; everything holds while halted.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            e_valid       <= '0;
            e_reg_write   <= '0;
            e_is_load     <= '0;
            e1_rs         <= '0;
            e1_rt         <= '0;
            e1_use_rs     <= 1'b0;
            e1_use_rt     <= 1'b0;
            o_stall_count <= '0;
            for (int unsigned j = 1; j <= DEPTH; j++) begin
                e_write_reg[j] <= '0;
            end
        end else if (!i_halt) begin
            e_valid     <= {e_valid[DEPTH-1:1], accept};
            e_reg_write <= {e_reg_write[DEPTH-1:1], i_id_reg_write};
            e_is_load   <= {e_is_load[DEPTH-1:1], i_id_mem_to_reg};
            for (int unsigned j = DEPTH; j >= 2; j--) begin
                e_write_reg[j] <= e_write_reg[j-1];
            end
            e_write_reg[1] <= i_id_write_reg;
            e1_rs          <= i_id_rs;
            e1_rt          <= i_id_rt;
            e1_use_rs      <= i_id_use_rs;
            e1_use_rt      <= i_id_use_rt;
            if (o_stall && (o_stall_count != '1)) begin
                o_stall_count <= o_stall_count + NB_CNT'(1);
            end
        end
    end

endmodule

// File: tb/tb_unit_forward_sb.sv
// Testbench for unit_forward_sb: two instances (DEPTH=3/LOAD_READY=3 and
// DEPTH=4/LOAD_READY=4), each fed its own instruction stream that advances only
// when that instance does not stall, checked against a queue-of-instructions model.
module tb_unit_forward_sb;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] wr;
        logic       rw;
        logic       ld;
    } ins_t;

    logic clk;
    logic rst_n;
    logic halt;
    logic flush;
    ins_t id3;
    ins_t id4;
    logic [1:0]  fa3, fb3, fa4, fb4;
    logic        st3, st4;
    logic [15:0] cnt3, cnt4;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: me[k][j] is the instruction j stages past ID.
    ins_t me [0:1][1:4];
    int   cnt_m [0:1];
    int   pc    [0:1];
    int   dep   [0:1];
    int   lr    [0:1];
    ins_t prog  [$];

    unit_forward_sb #(.NB_REG(5), .DEPTH(3), .LOAD_READY(3), .NB_SEL(2), .NB_CNT(16)) dut3 (
        .i_clock(clk), .i_reset(rst_n), .i_halt(halt), .i_flush(flush),
        .i_id_valid(id3.valid), .i_id_rs(id3.rs), .i_id_rt(id3.rt),
        .i_id_use_rs(id3.urs), .i_id_use_rt(id3.urt), .i_id_write_reg(id3.wr),
        .i_id_reg_write(id3.rw), .i_id_mem_to_reg(id3.ld),
        .o_forward_A(fa3), .o_forward_B(fb3), .o_stall(st3), .o_stall_count(cnt3)
    );

    unit_forward_sb #(.NB_REG(5), .DEPTH(4), .LOAD_READY(4), .NB_SEL(2), .NB_CNT(16)) dut4 (
        .i_clock(clk), .i_reset(rst_n), .i_halt(halt), .i_flush(flush),
        .i_id_valid(id4.valid), .i_id_rs(id4.rs), .i_id_rt(id4.rt),
        .i_id_use_rs(id4.urs), .i_id_use_rt(id4.urt), .i_id_write_reg(id4.wr),
        .i_id_reg_write(id4.rw), .i_id_mem_to_reg(id4.ld),
        .o_forward_A(fa4), .o_forward_B(fb4), .o_stall(st4), .o_stall_count(cnt4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic ins_t mk(input int rs, input int rt, input bit urs, input bit urt,
                                input int wr, input bit rw, input bit ld);
        ins_t r;
        r.valid = 1'b1;
        r.rs    = 5'(rs);
        r.rt    = 5'(rt);
        r.urs   = urs;
        r.urt   = urt;
        r.wr    = 5'(wr);
        r.rw    = rw;
        r.ld    = ld;
        return r;
    endfunction

    // Stage of the youngest in-flight writer of r at or beyond stage 'from'; 0 if none.
    function automatic int youngest(input int k, input int from, input logic [4:0] r);
        if (r == 5'd0) return 0;
        for (int j = from; j <= dep[k]; j++) begin
            if (me[k][j].valid && me[k][j].rw && me[k][j].wr == r) return j;
        end
        return 0;
    endfunction

    function automatic int exp_fwd(input int k, input bit use_op, input logic [4:0] r);
        int j;
        if (!me[k][1].valid || !use_op) return 0;
        j = youngest(k, 2, r);
        if (j == 0) return 0;
        if (!me[k][j].ld || j >= lr[k]) return dep[k] + 1 - j;
        return 0;
    endfunction

    function automatic bit exp_hz(input int k, input ins_t c);
        int j;
        if (!c.valid) return 1'b0;
        if (c.urs) begin
            j = youngest(k, 1, c.rs);
            if (j != 0 && me[k][j].ld && j <= lr[k] - 2) return 1'b1;
        end
        if (c.urt) begin
            j = youngest(k, 1, c.rt);
            if (j != 0 && me[k][j].ld && j <= lr[k] - 2) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic ins_t fetch(input int k);
        if (pc[k] < prog.size()) return prog[pc[k]];
        return ins_t'(0);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int j = 1; j <= 4; j++) me[k][j] = ins_t'(0);
            cnt_m[k] = 0;
        end
    endtask

    task automatic load_prog();
        pc[0] = 0;
        pc[1] = 0;
    endtask

    // One cycle: drive at negedge, check, advance the model, cross the posedge.
    task automatic step(input bit h, input bit f);
        ins_t cur [0:1];
        bit   st_e [0:1];
        for (int k = 0; k < 2; k++) cur[k] = fetch(k);
        id3   = cur[0];
        id4   = cur[1];
        halt  = h;
        flush = f;
        #1;
        for (int k = 0; k < 2; k++) st_e[k] = exp_hz(k, cur[k]) && !f;
        chk("d3_stall", 32'(st3),  32'(st_e[0]));
        chk("d3_fwdA",  32'(fa3),  32'(exp_fwd(0, me[0][1].urs, me[0][1].rs)));
        chk("d3_fwdB",  32'(fb3),  32'(exp_fwd(0, me[0][1].urt, me[0][1].rt)));
        chk("d3_count", 32'(cnt3), 32'(cnt_m[0]));
        chk("d4_stall", 32'(st4),  32'(st_e[1]));
        chk("d4_fwdA",  32'(fa4),  32'(exp_fwd(1, me[1][1].urs, me[1][1].rs)));
        chk("d4_fwdB",  32'(fb4),  32'(exp_fwd(1, me[1][1].urt, me[1][1].rt)));
        chk("d4_count", 32'(cnt4), 32'(cnt_m[1]));
        if (!h) begin
            for (int k = 0; k < 2; k++) begin
                for (int j = dep[k]; j >= 2; j--) me[k][j] = me[k][j-1];
                me[k][1] = (cur[k].valid && !st_e[k] && !f) ? cur[k] : ins_t'(0);
                if (st_e[k] && cnt_m[k] < 65535) cnt_m[k]++;
                if (!st_e[k]) pc[k]++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step(1'b0, 1'b0);
    endtask

    // Reset asserted with the current ID instruction still driven; everything reads 0.
    task automatic do_reset();
        id3   = fetch(0);
        id4   = fetch(1);
        halt  = 1'b0;
        flush = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_d3_fwdA",  32'(fa3),  32'd0);
        chk("rst_d3_fwdB",  32'(fb3),  32'd0);
        chk("rst_d3_stall", 32'(st3),  32'd0);
        chk("rst_d3_count", 32'(cnt3), 32'd0);
        chk("rst_d4_fwdA",  32'(fa4),  32'd0);
        chk("rst_d4_fwdB",  32'(fb4),  32'd0);
        chk("rst_d4_stall", 32'(st4),  32'd0);
        chk("rst_d4_count", 32'(cnt4), 32'd0);
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        ins_t r;
        clk   = 1'b0;
        rst_n = 1'b0;
        halt  = 1'b0;
        flush = 1'b0;
        id3   = ins_t'(0);
        id4   = ins_t'(0);
        dep[0] = 3; lr[0] = 3;
        dep[1] = 4; lr[1] = 4;
        model_clear();
        load_prog();

        // Power-on reset with an empty ID stage.
        do_reset();
        run(2);

        // ALU chain: add r2; sub reads rs=r2; or reads rt=r2. No stalls.
        prog.delete();
        prog.push_back(mk(1, 3, 1, 1, 2, 1, 0));
        prog.push_back(mk(2, 9, 1, 1, 6, 1, 0));
        prog.push_back(mk(8, 2, 1, 1, 7, 1, 0));
        load_prog();
        run(7);
        chk("alu_d3_nostall", 32'(cnt3), 32'd0);
        chk("alu_d4_nostall", 32'(cnt4), 32'd0);

        // Load-use: lw r4; add rs=r4. One stall at DEPTH 3, two at DEPTH 4.
        do_reset();
        prog.delete();
        prog.push_back(mk(1, 0, 1, 0, 4, 1, 1));
        prog.push_back(mk(4, 5, 1, 1, 6, 1, 0));
        load_prog();
        run(8);
        chk("lu_d3_count", 32'(cnt3), 32'd1);
        chk("lu_d4_count", 32'(cnt4), 32'd2);

        // Youngest writer wins; writes and loads to r0 never forward or stall.
        do_reset();
        prog.delete();
        prog.push_back(mk(1, 1, 1, 1, 5, 1, 0));
        prog.push_back(mk(1, 1, 1, 1, 5, 1, 0));
        prog.push_back(mk(5, 5, 1, 1, 9, 1, 0));
        prog.push_back(mk(1, 0, 1, 0, 0, 1, 1));
        prog.push_back(mk(0, 0, 1, 1, 0, 1, 0));
        prog.push_back(mk(0, 0, 1, 1, 3, 1, 0));
        load_prog();
        run(10);
        chk("r0_d3_count", 32'(cnt3), 32'd0);
        chk("r0_d4_count", 32'(cnt4), 32'd0);

        // Flush on the hazard cycle: no stall, counter untouched.
        do_reset();
        prog.delete();
        prog.push_back(mk(1, 0, 1, 0, 4, 1, 1));
        prog.push_back(mk(4, 4, 1, 1, 6, 1, 0));
        prog.push_back(mk(2, 3, 1, 1, 7, 1, 0));
        load_prog();
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        run(6);
        chk("fl_d3_count", 32'(cnt3), 32'd0);
        chk("fl_d4_count", 32'(cnt4), 32'd0);

        // Halt for three cycles in the middle of a load-use sequence.
        do_reset();
        prog.delete();
        prog.push_back(mk(1, 0, 1, 0, 4, 1, 1));
        prog.push_back(mk(4, 2, 1, 1, 6, 1, 0));
        prog.push_back(mk(3, 4, 1, 1, 7, 1, 0));
        load_prog();
        step(1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0);
        run(8);
        chk("ht_d3_count", 32'(cnt3), 32'd1);
        chk("ht_d4_count", 32'(cnt4), 32'd2);

        // Reset mid-stall with valid entries in flight.
        prog.delete();
        prog.push_back(mk(1, 0, 1, 0, 7, 1, 1));
        prog.push_back(mk(7, 7, 1, 1, 8, 1, 0));
        load_prog();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        do_reset();
        run(6);

        // Random streams over a small register set with random halt/flush/reset.
        prog.delete();
        for (int i = 0; i < 300; i++) begin
            r.valid = ($urandom_range(0, 7) != 0);
            r.rs    = 5'($urandom_range(0, 6));
            r.rt    = 5'($urandom_range(0, 6));
            r.urs   = 1'($urandom_range(0, 1));
            r.urt   = 1'($urandom_range(0, 1));
            r.wr    = 5'($urandom_range(0, 6));
            r.rw    = ($urandom_range(0, 3) != 0);
            r.ld    = r.rw && ($urandom_range(0, 2) == 0);
            prog.push_back(r);
        end
        load_prog();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
